// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed data memory sitting behind the processor's multi-cycle
//   load/store port. One request is taken at a time over a valid/ready
//   handshake. After WAIT_CYCLES wait states the memory is accessed, and the
//   result is presented on a valid/ready response channel until it is taken.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (0 = in reset)
//   req_valid  request present          req_ready  request can be taken
//   req_write  1 = store, 0 = load      req_addr   byte address
//   req_wdata  store data               req_be     store byte enables
//   rsp_valid  response present         rsp_ready  response taken
//   rsp_rdata  load data (0 for stores / errors)
//   rsp_error  misaligned or out-of-range request
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         mem_q [DEPTH];

  logic                accept;
  logic                do_access;
  logic                acc_write;
  logic [ADDR_W-1:0]   acc_addr;
  logic [31:0]         acc_wdata;
  logic [3:0]          acc_be;
  logic [IDX_W-1:0]    acc_idx;
  logic                acc_err;
  logic [31:0]         acc_rdata;

  // The ready term is gated by reset so the port reads 0 while in reset.
  assign req_ready = (state_q == S_IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

  // With no wait states the access happens on the acceptance edge, so the
  // operands come straight from the request port instead of the latches.
  assign acc_write = (WAIT_CYCLES == 0) ? req_write : write_q;
  assign acc_addr  = (WAIT_CYCLES == 0) ? req_addr  : addr_q;
  assign acc_wdata = (WAIT_CYCLES == 0) ? req_wdata : wdata_q;
  assign acc_be    = (WAIT_CYCLES == 0) ? req_be    : be_q;
  assign do_access = (WAIT_CYCLES == 0) ? accept
                                        : ((state_q == S_WAIT) && (cnt_q == 4'd1));

  assign acc_idx   = acc_addr[IDX_W+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00) ||
                     ({2'b00, acc_addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH));
  assign acc_rdata = (acc_err || acc_write) ? '0 : mem_q[acc_idx];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            rdata_d = acc_rdata;
            err_d   = acc_err;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          rdata_d = acc_rdata;
          err_d   = acc_err;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset. A reset during WAIT returns the FSM to
  // IDLE before the access edge, so the pending store never reaches here.
  always_ff @(posedge clk) begin
    if (do_access && acc_write && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
